ein_rx: RTL and testbench

//  Receiver for the three-wire EMO/EDI/ECI pad interface: the inverse of the EIN transmit path.

---
 rtl/ein_rx_if.sv | 27 ++
 rtl/ein_rx.sv | 158 +++++++++++++++
 tb/tb_ein_rx.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ein_rx_if.sv
// rtl/ein_rx_if.sv - received-byte and frame-status bundle from the EIN receiver
interface ein_rx_if;
    logic [7:0] out_data;
    logic       out_data_valid;
    logic       out_frame_valid;
    logic       out_frame_end;
    logic       err_partial;
    logic       err_timeout;

    modport master (
        output out_data,
        output out_data_valid,
        output out_frame_valid,
        output out_frame_end,
        output err_partial,
        output err_timeout
    );

    modport slave (
        input out_data,
        input out_data_valid,
        input out_frame_valid,
        input out_frame_end,
        input err_partial,
        input err_timeout
    );
endinterface

// File: rtl/ein_rx.sv
// rtl/ein_rx.sv - EMO/EDI/ECI pad receiver: sync, frame, MSB-first deserialise, error detect
module ein_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int TO_W        = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            EMO_IN,
    input  logic            EDI_IN,
    input  logic            ECI_IN,
    input  logic            rx_enable,
    input  logic [TO_W-1:0] TIMEOUT,
    ein_rx_if.master        rx
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        WAIT_RELEASE
    } state_t;

    logic [SYNC_STAGES-1:0] emo_sync;
    logic [SYNC_STAGES-1:0] edi_sync;
    logic [SYNC_STAGES-1:0] eci_sync;
    logic                   emo_prev;
    logic                   eci_prev;

    state_t          state, state_n;
    logic [7:0]      shift, shift_n;
    logic [2:0]      bit_cnt, bit_cnt_n;
    logic [TO_W-1:0] to_cnt, to_cnt_n;
    logic [7:0]      data_r, data_n;
    logic            dv_r, dv_n;
    logic            fe_r, fe_n;
    logic            ep_r, ep_n;
    logic            et_r, et_n;

    logic       emo_s, edi_s, eci_s;
    logic       emo_rise, emo_fall, eci_rise;
    logic       to_hit;
    logic [7:0] shifted;

    // EDI is taken from the same synchroniser depth as ECI so data and clock stay aligned
    assign emo_s    = emo_sync[SYNC_STAGES-1];
    assign edi_s    = edi_sync[SYNC_STAGES-1];
    assign eci_s    = eci_sync[SYNC_STAGES-1];
    assign emo_rise = emo_s & ~emo_prev;
    assign emo_fall = ~emo_s & emo_prev;
    assign eci_rise = eci_s & ~eci_prev;
    assign to_hit   = (TIMEOUT != '0) && (to_cnt == TIMEOUT - TO_W'(1));
    assign shifted  = {shift[6:0], edi_s};

    // Pad synchronisers plus one history register for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            emo_sync <= '0;
            edi_sync <= '0;
            eci_sync <= '0;
            emo_prev <= 1'b0;
            eci_prev <= 1'b0;
        end else begin
            emo_sync <= {emo_sync[SYNC_STAGES-2:0], EMO_IN};
            edi_sync <= {edi_sync[SYNC_STAGES-2:0], EDI_IN};
            eci_sync <= {eci_sync[SYNC_STAGES-2:0], ECI_IN};
            emo_prev <= emo_s;
            eci_prev <= eci_s;
        end
    end

    // FSM state, datapath and registered strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            to_cnt  <= '0;
            data_r  <= '0;
            dv_r    <= 1'b0;
            fe_r    <= 1'b0;
            ep_r    <= 1'b0;
            et_r    <= 1'b0;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            bit_cnt <= bit_cnt_n;
            to_cnt  <= to_cnt_n;
            data_r  <= data_n;
            dv_r    <= dv_n;
            fe_r    <= fe_n;
            ep_r    <= ep_n;
            et_r    <= et_n;
        end
    end

    // Next state: EMO fall beats every other event in the same edge cycle, then enable, then ECI, then timeout
    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_cnt_n = bit_cnt;
        to_cnt_n  = to_cnt;
        data_n    = data_r;
        dv_n      = 1'b0;
        fe_n      = 1'b0;
        ep_n      = 1'b0;
        et_n      = 1'b0;
        case (state)
            IDLE: begin
                if (rx_enable && emo_rise) begin
                    state_n   = ACTIVE;
                    shift_n   = '0;
                    bit_cnt_n = '0;
                    to_cnt_n  = '0;
                end
            end
            ACTIVE: begin
                if (emo_fall) begin
                    fe_n      = 1'b1;
                    ep_n      = (bit_cnt != 3'd0);
                    bit_cnt_n = '0;
                    state_n   = IDLE;
                end else if (!rx_enable) begin
                    fe_n      = 1'b1;
                    bit_cnt_n = '0;
                    state_n   = WAIT_RELEASE;
                end else if (eci_rise && emo_s) begin
                    shift_n   = shifted;
                    bit_cnt_n = bit_cnt + 3'd1;
                    to_cnt_n  = '0;
                    if (bit_cnt == 3'd7) begin
                        data_n = shifted;
                        dv_n   = 1'b1;
                    end
                end else if (to_hit) begin
                    et_n      = 1'b1;
                    fe_n      = 1'b1;
                    bit_cnt_n = '0;
                    state_n   = WAIT_RELEASE;
                end else if (to_cnt != '1) begin
                    to_cnt_n = to_cnt + TO_W'(1);
                end
            end
            WAIT_RELEASE: begin
                if (!emo_s) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign rx.out_data        = data_r;
    assign rx.out_data_valid  = dv_r;
    assign rx.out_frame_valid = (state == ACTIVE);
    assign rx.out_frame_end   = fe_r;
    assign rx.err_partial     = ep_r;
    assign rx.err_timeout     = et_r;

endmodule

// File: tb/tb_ein_rx.sv
// tb/tb_ein_rx.sv - scoreboard bench for ein_rx
module tb_ein_rx;

    localparam int SYNC_STAGES = 2;
    localparam int TO_W        = 32;

    typedef struct packed {
        logic partial;
        logic tmo;
    } end_t;

    logic            clk;
    logic            reset;
    logic            emo;
    logic            edi;
    logic            eci;
    logic            rx_enable;
    logic [TO_W-1:0] timeout;

    ein_rx_if rx ();

    ein_rx #(
        .SYNC_STAGES(SYNC_STAGES),
        .TO_W       (TO_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .EMO_IN   (emo),
        .EDI_IN   (edi),
        .ECI_IN   (eci),
        .rx_enable(rx_enable),
        .TIMEOUT  (timeout),
        .rx       (rx)
    );

    int         n_checks;
    int         n_fail;
    logic [7:0] data_q[$];
    end_t       end_q[$];
    logic [7:0] exp_b;
    end_t       exp_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        edi = b;
        tick(4);
        eci = 1'b1;
        tick(4);
        eci = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit expect_strobe);
        if (expect_strobe) data_q.push_back(b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic frame_open();
        emo = 1'b1;
        tick(6);
    endtask

    task automatic frame_close(input bit expect_end, input logic partial, input logic tmo);
        end_t e;
        e.partial = partial;
        e.tmo     = tmo;
        if (expect_end) end_q.push_back(e);
        emo = 1'b0;
        tick(8);
    endtask

    task automatic test_reset();
        tick(1);
        n_checks += 6;
        if (rx.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h, required 00", rx.out_data); end
        if (rx.out_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b, required 0", rx.out_data_valid); end
        if (rx.out_frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_frame_valid: got %b, required 0", rx.out_frame_valid); end
        if (rx.out_frame_end !== 1'b0) begin n_fail++; $display("FAIL reset_frame_end: got %b, required 0", rx.out_frame_end); end
        if (rx.err_partial !== 1'b0) begin n_fail++; $display("FAIL reset_err_partial: got %b, required 0", rx.err_partial); end
        if (rx.err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err_timeout: got %b, required 0", rx.err_timeout); end
        reset = 1'b0;
        tick(4);
    endtask

    task automatic test_two_bytes();
        timeout = '0;
        frame_open();
        n_checks++;
        if (rx.out_frame_valid !== 1'b1) begin n_fail++; $display("FAIL t1_frame_valid_open: got %b, required 1", rx.out_frame_valid); end
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        frame_close(1'b1, 1'b0, 1'b0);
        n_checks += 4;
        if (rx.out_frame_valid !== 1'b0) begin n_fail++; $display("FAIL t1_frame_valid_closed: got %b, required 0", rx.out_frame_valid); end
        if (rx.out_data !== 8'h3C) begin n_fail++; $display("FAIL t1_data_hold: got %h, required 3c", rx.out_data); end
        if (data_q.size() != 0) begin n_fail++; $display("FAIL t1_bytes_missing: got %0d left, required 0", data_q.size()); end
        if (end_q.size() != 0) begin n_fail++; $display("FAIL t1_end_missing: got %0d left, required 0", end_q.size()); end
    endtask

    task automatic test_partial();
        frame_open();
        send_byte(8'hF0, 1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        frame_close(1'b1, 1'b1, 1'b0);
        n_checks += 2;
        if (data_q.size() != 0) begin n_fail++; $display("FAIL t2_bytes_missing: got %0d left, required 0", data_q.size()); end
        if (end_q.size() != 0) begin n_fail++; $display("FAIL t2_end_missing: got %0d left, required 0", end_q.size()); end
    endtask

    task automatic test_timeout();
        int   k;
        end_t e;
        timeout = 32'd100;
        frame_open();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        e.partial = 1'b0;
        e.tmo     = 1'b1;
        end_q.push_back(e);
        edi = 1'b1;
        tick(4);
        eci = 1'b1;
        k = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rx.err_timeout === 1'b1) begin
                k = i;
                break;
            end
        end
        n_checks += 2;
        if (k != SYNC_STAGES + 1 + 100) begin n_fail++; $display("FAIL t3_timeout_delay: got %0d clocks, required %0d", k, SYNC_STAGES + 1 + 100); end
        if (rx.out_frame_valid !== 1'b0) begin n_fail++; $display("FAIL t3_frame_valid_abort: got %b, required 0", rx.out_frame_valid); end
        tick(1);
        eci = 1'b0;
        send_byte(8'hFF, 1'b0);
        frame_close(1'b0, 1'b0, 1'b0);
        frame_open();
        send_byte(8'h5A, 1'b1);
        frame_close(1'b1, 1'b0, 1'b0);
        n_checks += 2;
        if (data_q.size() != 0) begin n_fail++; $display("FAIL t3_bytes_missing: got %0d left, required 0", data_q.size()); end
        if (end_q.size() != 0) begin n_fail++; $display("FAIL t3_end_missing: got %0d left, required 0", end_q.size()); end
    endtask

    task automatic test_no_timeout();
        timeout = '0;
        frame_open();
        data_q.push_back(8'hC3);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        tick(30000);
        n_checks++;
        if (rx.out_frame_valid !== 1'b1) begin n_fail++; $display("FAIL t4_frame_valid_idle: got %b, required 1", rx.out_frame_valid); end
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        frame_close(1'b1, 1'b0, 1'b0);
        n_checks += 2;
        if (data_q.size() != 0) begin n_fail++; $display("FAIL t4_bytes_missing: got %0d left, required 0", data_q.size()); end
        if (end_q.size() != 0) begin n_fail++; $display("FAIL t4_end_missing: got %0d left, required 0", end_q.size()); end
    endtask

    task automatic test_same_edge();
        end_t e;
        frame_open();
        for (int i = 0; i < 7; i++) send_bit(i[0]);
        e.partial = 1'b1;
        e.tmo     = 1'b0;
        end_q.push_back(e);
        edi = 1'b1;
        tick(4);
        emo = 1'b0;
        eci = 1'b1;
        tick(8);
        eci = 1'b0;
        tick(4);
        n_checks += 3;
        if (rx.out_frame_valid !== 1'b0) begin n_fail++; $display("FAIL t5_frame_valid: got %b, required 0", rx.out_frame_valid); end
        if (data_q.size() != 0) begin n_fail++; $display("FAIL t5_bytes_missing: got %0d left, required 0", data_q.size()); end
        if (end_q.size() != 0) begin n_fail++; $display("FAIL t5_end_missing: got %0d left, required 0", end_q.size()); end
    endtask

    task automatic test_enable();
        rx_enable = 1'b0;
        frame_open();
        n_checks++;
        if (rx.out_frame_valid !== 1'b0) begin n_fail++; $display("FAIL en_frame_valid_disabled: got %b, required 0", rx.out_frame_valid); end
        send_byte(8'h11, 1'b0);
        frame_close(1'b0, 1'b0, 1'b0);
        rx_enable = 1'b1;
        frame_open();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        end_q.push_back('0);
        rx_enable = 1'b0;
        tick(3);
        n_checks++;
        if (rx.out_frame_valid !== 1'b0) begin n_fail++; $display("FAIL en_frame_valid_abort: got %b, required 0", rx.out_frame_valid); end
        rx_enable = 1'b1;
        send_byte(8'h77, 1'b0);
        frame_close(1'b0, 1'b0, 1'b0);
        n_checks += 2;
        if (data_q.size() != 0) begin n_fail++; $display("FAIL en_bytes_missing: got %0d left, required 0", data_q.size()); end
        if (end_q.size() != 0) begin n_fail++; $display("FAIL en_end_missing: got %0d left, required 0", end_q.size()); end
    endtask

    task automatic test_async_reset();
        frame_open();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        reset = 1'b1;
        #2;
        n_checks += 2;
        if (rx.out_frame_valid !== 1'b0) begin n_fail++; $display("FAIL t6_frame_valid_reset: got %b, required 0", rx.out_frame_valid); end
        if (rx.out_data !== 8'h00) begin n_fail++; $display("FAIL t6_out_data_reset: got %h, required 00", rx.out_data); end
        emo = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(4);
        frame_open();
        send_byte(8'h81, 1'b1);
        frame_close(1'b1, 1'b0, 1'b0);
        n_checks += 3;
        if (rx.out_data !== 8'h81) begin n_fail++; $display("FAIL t6_data_hold: got %h, required 81", rx.out_data); end
        if (data_q.size() != 0) begin n_fail++; $display("FAIL t6_bytes_missing: got %0d left, required 0", data_q.size()); end
        if (end_q.size() != 0) begin n_fail++; $display("FAIL t6_end_missing: got %0d left, required 0", end_q.size()); end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        emo       = 1'b0;
        edi       = 1'b0;
        eci       = 1'b0;
        rx_enable = 1'b1;
        timeout   = '0;

        fork
            forever begin
                @(negedge clk);
                if (rx.out_data_valid === 1'b1) begin
                    n_checks++;
                    if (data_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL data_strobe_unexpected: got %h, required no strobe", rx.out_data);
                    end else begin
                        exp_b = data_q.pop_front();
                        if (rx.out_data !== exp_b) begin
                            n_fail++;
                            $display("FAIL data_value: got %h, required %h", rx.out_data, exp_b);
                        end
                    end
                end
                if (rx.out_frame_end === 1'b1) begin
                    n_checks++;
                    if (end_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL frame_end_unexpected: got strobe, required none");
                    end else begin
                        exp_e = end_q.pop_front();
                        if ({rx.err_partial, rx.err_timeout} !== {exp_e.partial, exp_e.tmo}) begin
                            n_fail++;
                            $display("FAIL frame_end_flags: got partial=%b timeout=%b, required partial=%b timeout=%b",
                                     rx.err_partial, rx.err_timeout, exp_e.partial, exp_e.tmo);
                        end
                    end
                end else if ((rx.err_partial | rx.err_timeout) !== 1'b0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL err_without_end: got partial=%b timeout=%b, required 0 0", rx.err_partial, rx.err_timeout);
                end
            end
        join_none

        test_reset();
        test_two_bytes();
        test_partial();
        test_timeout();
        test_no_timeout();
        test_same_edge();
        test_enable();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
